// File: rtl/pipe_acc_4_pkg.sv
// Shared definitions for the dot-product accumulation stage: default width, tag and FSM encodings.
package pipe_acc_4_pkg;

  localparam int WORD_LEN_DEF = 32;

  localparam logic TAG_RE = 1'b0;
  localparam logic TAG_IM = 1'b1;

  typedef enum logic {
    ACC_IDLE = 1'b0,
    ACC_RUN  = 1'b1
  } acc_state_e;

  // Headroom needed to sum k full-scale terms without wrapping.
  function automatic int guard_bits(input int k);
    return $clog2(k) + 1;
  endfunction

endpackage

// File: rtl/pipe_acc_4_sat.sv
// Combinational saturator: narrows a wide signed accumulator to OUT_W bits and flags any clip.
module pipe_acc_4_sat #(
  parameter int IN_W  = 35,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  din_i,
  output logic [OUT_W-1:0] dout_o,
  output logic             clip_o
);

  localparam int HB = IN_W - OUT_W + 1;

  logic [HB-1:0] top_s;

  // The value fits when every bit above the target sign bit repeats that sign bit.
  always_comb begin
    top_s = din_i[IN_W-1:OUT_W-1];
    if ((top_s == {HB{1'b0}}) || (top_s == {HB{1'b1}})) begin
      dout_o = din_i[OUT_W-1:0];
      clip_o = 1'b0;
    end else if (din_i[IN_W-1] == 1'b1) begin
      dout_o = {1'b1, {(OUT_W-1){1'b0}}};
      clip_o = 1'b1;
    end else begin
      dout_o = {1'b0, {(OUT_W-1){1'b1}}};
      clip_o = 1'b1;
    end
  end

endmodule

// File: rtl/pipe_acc_4.sv
// Complex dot-product accumulator: sums K_LEN real and K_LEN imag terms into one saturated
// element held in a valid/ready output register.
module pipe_acc_4
  import pipe_acc_4_pkg::*;
#(
  parameter int WORD_LEN = WORD_LEN_DEF,
  parameter int K_LEN    = 4,
  parameter int GUARD    = guard_bits(K_LEN)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we_in,
  input  logic                state,
  input  logic [WORD_LEN-1:0] data_in,
  input  logic                clear,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [WORD_LEN-1:0] out_re,
  output logic [WORD_LEN-1:0] out_im,
  output logic [1:0]          out_sat,
  output logic                ovf_err,
  output logic                seq_err
);

  localparam int AW = WORD_LEN + GUARD;
  localparam int CW = $clog2(K_LEN + 1);
  localparam logic [CW-1:0] K_CNT = CW'(K_LEN);

  acc_state_e st_q, st_d;

  logic [AW-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic [CW-1:0] cnt_re_q, cnt_re_d, cnt_im_q, cnt_im_d;

  logic                out_valid_q, out_valid_d;
  logic [WORD_LEN-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
  logic [1:0]          out_sat_q, out_sat_d;
  logic                ovf_err_q, ovf_err_d, seq_err_q, seq_err_d;

  logic [AW-1:0]       ext_s, base_re_s, base_im_s, sum_re_s, sum_im_s;
  logic [CW-1:0]       cnt_re_nx_s, cnt_im_nx_s;
  logic                accept_s, take_re_s, take_im_s, seq_hit_s, complete_s;
  logic [WORD_LEN-1:0] sat_re_s, sat_im_s;
  logic                clip_re_s, clip_im_s;

  // Term decode: a term whose tag already holds K_LEN entries is dropped and flagged.
  always_comb begin
    ext_s       = {{GUARD{data_in[WORD_LEN-1]}}, data_in};
    accept_s    = we_in & ~clear;
    take_re_s   = accept_s & (state == TAG_RE) & (cnt_re_q != K_CNT);
    take_im_s   = accept_s & (state == TAG_IM) & (cnt_im_q != K_CNT);
    seq_hit_s   = accept_s & ~take_re_s & ~take_im_s;
    cnt_re_nx_s = cnt_re_q + CW'(take_re_s);
    cnt_im_nx_s = cnt_im_q + CW'(take_im_s);
    sum_re_s    = base_re_s + (take_re_s ? ext_s : {AW{1'b0}});
    sum_im_s    = base_im_s + (take_im_s ? ext_s : {AW{1'b0}});
    complete_s  = (take_re_s | take_im_s) & (cnt_re_nx_s == K_CNT) & (cnt_im_nx_s == K_CNT);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= ACC_IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  // FSM next state: an element ends on completion or abort.
  always_comb begin
    st_d = st_q;
    case (st_q)
      ACC_IDLE: begin
        if (!clear && (take_re_s || take_im_s) && !complete_s) begin
          st_d = ACC_RUN;
        end else begin
          st_d = ACC_IDLE;
        end
      end
      ACC_RUN: begin
        if (clear || complete_s) begin
          st_d = ACC_IDLE;
        end else begin
          st_d = ACC_RUN;
        end
      end
      default: st_d = ACC_IDLE;
    endcase
  end

  // FSM outputs: a fresh element starts from zero rather than from the stored sums.
  always_comb begin
    base_re_s = {AW{1'b0}};
    base_im_s = {AW{1'b0}};
    case (st_q)
      ACC_RUN: begin
        base_re_s = acc_re_q;
        base_im_s = acc_im_q;
      end
      ACC_IDLE: begin
        base_re_s = {AW{1'b0}};
        base_im_s = {AW{1'b0}};
      end
      default: begin
        base_re_s = {AW{1'b0}};
        base_im_s = {AW{1'b0}};
      end
    endcase
  end

  pipe_acc_4_sat #(.IN_W(AW), .OUT_W(WORD_LEN)) u_sat_re (
    .din_i  (sum_re_s),
    .dout_o (sat_re_s),
    .clip_o (clip_re_s)
  );

  pipe_acc_4_sat #(.IN_W(AW), .OUT_W(WORD_LEN)) u_sat_im (
    .din_i  (sum_im_s),
    .dout_o (sat_im_s),
    .clip_o (clip_im_s)
  );

  // Accumulator and counter next state.
  always_comb begin
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    cnt_re_d = cnt_re_q;
    cnt_im_d = cnt_im_q;
    if (clear || complete_s) begin
      acc_re_d = {AW{1'b0}};
      acc_im_d = {AW{1'b0}};
      cnt_re_d = {CW{1'b0}};
      cnt_im_d = {CW{1'b0}};
    end else begin
      acc_re_d = sum_re_s;
      acc_im_d = sum_im_s;
      cnt_re_d = cnt_re_nx_s;
      cnt_im_d = cnt_im_nx_s;
    end
  end

  // Output register: a completion only lands if the slot is empty or being drained this edge.
  always_comb begin
    out_valid_d = out_valid_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    out_sat_d   = out_sat_q;
    ovf_err_d   = ovf_err_q | (complete_s & out_valid_q & ~out_ready);
    seq_err_d   = seq_err_q | seq_hit_s;
    if (complete_s && (!out_valid_q || out_ready)) begin
      out_valid_d = 1'b1;
      out_re_d    = sat_re_s;
      out_im_d    = sat_im_s;
      out_sat_d   = {clip_im_s, clip_re_s};
    end else if (!complete_s && out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_re_q    <= {AW{1'b0}};
      acc_im_q    <= {AW{1'b0}};
      cnt_re_q    <= {CW{1'b0}};
      cnt_im_q    <= {CW{1'b0}};
      out_valid_q <= 1'b0;
      out_re_q    <= {WORD_LEN{1'b0}};
      out_im_q    <= {WORD_LEN{1'b0}};
      out_sat_q   <= 2'b00;
      ovf_err_q   <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      acc_re_q    <= acc_re_d;
      acc_im_q    <= acc_im_d;
      cnt_re_q    <= cnt_re_d;
      cnt_im_q    <= cnt_im_d;
      out_valid_q <= out_valid_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      out_sat_q   <= out_sat_d;
      ovf_err_q   <= ovf_err_d;
      seq_err_q   <= seq_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign out_sat   = out_sat_q;
  assign ovf_err   = ovf_err_q;
  assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_pipe_acc_4.sv
// Bench for pipe_acc_4: directed scenarios plus random traffic checked against a queue-based model.
module tb_pipe_acc_4;

  localparam int W = 32;
  localparam int K = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         we_in = 1'b0;
  logic         state = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         clear = 1'b0;
  logic         out_ready = 1'b0;
  logic         out_valid, ovf_err, seq_err;
  logic [W-1:0] out_re, out_im;
  logic [1:0]   out_sat;

  pipe_acc_4 #(.WORD_LEN(W), .K_LEN(K)) dut (
    .clk(clk), .rst_n(rst_n), .we_in(we_in), .state(state), .data_in(data_in),
    .clear(clear), .out_ready(out_ready), .out_valid(out_valid), .out_re(out_re),
    .out_im(out_im), .out_sat(out_sat), .ovf_err(ovf_err), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model state: pending terms per tag, and the expected output register.
  longint       re_q[$];
  longint       im_q[$];
  logic         m_valid, m_ovf, m_seq;
  logic [W-1:0] m_re, m_im;
  logic [1:0]   m_sat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] sat_val(input longint s, output logic clip);
    longint hi, lo;
    hi = 64'sd2147483647;
    lo = -64'sd2147483648;
    clip = 1'b1;
    if (s > hi) return 32'h7FFF_FFFF;
    if (s < lo) return 32'h8000_0000;
    clip = 1'b0;
    return s[W-1:0];
  endfunction

  task automatic model_reset();
    re_q.delete();
    im_q.delete();
    m_valid = 1'b0; m_ovf = 1'b0; m_seq = 1'b0;
    m_re = '0; m_im = '0; m_sat = 2'b00;
  endtask

  task automatic model_edge(input logic we, input logic st, input logic [W-1:0] d,
                            input logic clr, input logic rdy);
    logic   done, c_re, c_im;
    longint s_re, s_im;
    logic [W-1:0] v_re, v_im;
    done = 1'b0;
    if (clr) begin
      re_q.delete();
      im_q.delete();
    end else if (we) begin
      if (st == 1'b0) begin
        if (re_q.size() < K) re_q.push_back(longint'($signed(d)));
        else m_seq = 1'b1;
      end else begin
        if (im_q.size() < K) im_q.push_back(longint'($signed(d)));
        else m_seq = 1'b1;
      end
      done = (re_q.size() == K) && (im_q.size() == K);
    end
    if (done) begin
      s_re = 0; s_im = 0;
      foreach (re_q[i]) s_re += re_q[i];
      foreach (im_q[i]) s_im += im_q[i];
      v_re = sat_val(s_re, c_re);
      v_im = sat_val(s_im, c_im);
      if (!m_valid || rdy) begin
        m_valid = 1'b1; m_re = v_re; m_im = v_im; m_sat = {c_im, c_re};
      end else begin
        m_ovf = 1'b1;
      end
      re_q.delete();
      im_q.delete();
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_all(input string where);
    chk({where, ".valid"}, 64'(out_valid), 64'(m_valid));
    chk({where, ".re"},    64'(out_re),    64'(m_re));
    chk({where, ".im"},    64'(out_im),    64'(m_im));
    chk({where, ".sat"},   64'(out_sat),   64'(m_sat));
    chk({where, ".ovf"},   64'(ovf_err),   64'(m_ovf));
    chk({where, ".seq"},   64'(seq_err),   64'(m_seq));
  endtask

  task automatic step(input logic we, input logic st, input logic [W-1:0] d,
                      input logic clr, input logic rdy);
    @(negedge clk);
    we_in = we; state = st; data_in = d; clear = clr; out_ready = rdy;
    @(posedge clk);
    model_edge(we, st, d, clr, rdy);
    #1;
    check_all("cyc");
  endtask

  // Asserts rst_n between edges and expects every output to drop before the next edge.
  task automatic do_reset();
    @(negedge clk);
    we_in = 1'b0; clear = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    model_edge(1'b0, 1'b0, '0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst.async_valid", 64'(out_valid), 64'd0);
    check_all("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic element(input logic [W-1:0] r0, input logic [W-1:0] rs,
                         input logic [W-1:0] i0, input logic [W-1:0] is_,
                         input logic rdy_body, input logic rdy_last);
    for (int i = 0; i < K; i++) begin
      step(1'b1, 1'b0, r0 + rs * W'(i), 1'b0, rdy_body);
      step(1'b1, 1'b1, i0 + is_ * W'(i), 1'b0, (i == K - 1) ? rdy_last : rdy_body);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    case ($urandom_range(0, 3))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      default: return 32'($urandom_range(0, 2000)) - 32'd1000;
    endcase
  endfunction

  initial begin
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: 1..4 real, 10..40 imag, consumer ready
    element(32'd1, 32'd1, 32'd10, 32'd10, 1'b1, 1'b1);
    chk("t1.re", 64'(out_re), 64'd10);
    chk("t1.im", 64'(out_im), 64'd100);
    chk("t1.valid", 64'(out_valid), 64'd1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("t1.drain", 64'(out_valid), 64'd0);

    // 2: saturation both directions
    element(32'h7FFF_FFFF, 32'd0, 32'h8000_0000, 32'd0, 1'b1, 1'b1);
    chk("t2.re", 64'(out_re), 64'h7FFF_FFFF);
    chk("t2.im", 64'(out_im), 64'h8000_0000);
    chk("t2.sat", 64'(out_sat), 64'd3);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // 3a: second completion while held and not ready
    element(32'd1, 32'd0, 32'd1, 32'd0, 1'b0, 1'b0);
    element(32'd2, 32'd0, 32'd2, 32'd0, 1'b0, 1'b0);
    chk("t3a.re", 64'(out_re), 64'd4);
    chk("t3a.ovf", 64'(ovf_err), 64'd1);
    do_reset();
    // 3b: drained on the same edge the next element lands
    element(32'd1, 32'd0, 32'd1, 32'd0, 1'b0, 1'b0);
    element(32'd2, 32'd0, 32'd2, 32'd0, 1'b0, 1'b1);
    chk("t3b.re", 64'(out_re), 64'd8);
    chk("t3b.valid", 64'(out_valid), 64'd1);
    chk("t3b.ovf", 64'(ovf_err), 64'd0);
    do_reset();

    // 4: fifth real term before the fourth imag term
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, W'(i), 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, W'(i), 1'b0, 1'b1);
    chk("t4.re", 64'(out_re), 64'd10);
    chk("t4.seq", 64'(seq_err), 64'd1);
    do_reset();

    // 5: abort after two real terms, then a clean element
    step(1'b1, 1'b0, 32'd7, 1'b0, 1'b1);
    step(1'b1, 1'b0, 32'd9, 1'b0, 1'b1);
    step(1'b1, 1'b0, 32'd5, 1'b1, 1'b1);
    element(32'd1, 32'd1, 32'd1, 32'd1, 1'b1, 1'b1);
    chk("t5.re", 64'(out_re), 64'd10);
    chk("t5.im", 64'(out_im), 64'd10);

    // 6: reset mid-element, then reset with a held element
    step(1'b1, 1'b0, 32'd3, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'd3, 1'b0, 1'b0);
    do_reset();
    element(32'd5, 32'd0, 32'd6, 32'd0, 1'b0, 1'b0);
    do_reset();
    element(32'd1, 32'd1, 32'd10, 32'd10, 1'b1, 1'b1);
    chk("t6.re", 64'(out_re), 64'd10);
    chk("t6.im", 64'(out_im), 64'd100);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), rand_word(),
             $urandom_range(0, 49) == 0, 1'($urandom_range(0, 1)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
